// File: rtl/io_arbiter.sv
// io_arbiter: two-port arbiter in front of the single I/O bridge (level-held do, pulsed done).
// One read or write is granted at a time; done and read data go back only to the owning port.
module io_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_read_do,
    input  logic [15:0] p0_read_address,
    input  logic [2:0]  p0_read_length,
    output logic [31:0] p0_read_data,
    output logic        p0_read_done,
    input  logic        p0_write_do,
    input  logic [15:0] p0_write_address,
    input  logic [2:0]  p0_write_length,
    input  logic [31:0] p0_write_data,
    output logic        p0_write_done,
    input  logic        p1_read_do,
    input  logic [15:0] p1_read_address,
    input  logic [2:0]  p1_read_length,
    output logic [31:0] p1_read_data,
    output logic        p1_read_done,
    input  logic        p1_write_do,
    input  logic [15:0] p1_write_address,
    input  logic [2:0]  p1_write_length,
    input  logic [31:0] p1_write_data,
    output logic        p1_write_done,
    output logic        io_read_do,
    output logic [15:0] io_read_address,
    output logic [2:0]  io_read_length,
    input  logic [31:0] io_read_data,
    input  logic        io_read_done,
    output logic        io_write_do,
    output logic [15:0] io_write_address,
    output logic [2:0]  io_write_length,
    output logic [31:0] io_write_data,
    input  logic        io_write_done,
    output logic        grant_owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t      state;
    logic        rr_ptr;
    logic        p0_wr_elig, p0_rd_elig, p1_wr_elig, p1_rd_elig;
    logic        p0_elig, p1_elig;
    logic        pick, pick_write;
    logic [15:0] pick_addr;
    logic [2:0]  pick_len;
    logic [31:0] pick_wdata;

    // The done guard stops a request from being re-granted in the cycle its pulse is visible.
    assign p0_wr_elig = p0_write_do && !p0_write_done;
    assign p0_rd_elig = p0_read_do  && !p0_read_done;
    assign p1_wr_elig = p1_write_do && !p1_write_done;
    assign p1_rd_elig = p1_read_do  && !p1_read_done;
    assign p0_elig    = p0_wr_elig || p0_rd_elig;
    assign p1_elig    = p1_wr_elig || p1_rd_elig;

    always_comb begin
        pick       = 1'b0;
        pick_addr  = '0;
        pick_len   = '0;
        if (p0_elig && p1_elig) begin
            pick = (FIXED_PRIORITY != 0) ? 1'b0 : rr_ptr;
        end else begin
            pick = p1_elig;
        end
        pick_write = pick ? p1_wr_elig : p0_wr_elig;
        if (pick_write) begin
            pick_addr = pick ? p1_write_address : p0_write_address;
            pick_len  = pick ? p1_write_length  : p0_write_length;
        end else begin
            pick_addr = pick ? p1_read_address : p0_read_address;
            pick_len  = pick ? p1_read_length  : p0_read_length;
        end
        pick_wdata = pick ? p1_write_data : p0_write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= 1'b0;
            grant_owner      <= 1'b0;
            busy             <= 1'b0;
            io_read_do       <= 1'b0;
            io_read_address  <= '0;
            io_read_length   <= '0;
            io_write_do      <= 1'b0;
            io_write_address <= '0;
            io_write_length  <= '0;
            io_write_data    <= '0;
            p0_read_data     <= '0;
            p1_read_data     <= '0;
            p0_read_done     <= 1'b0;
            p1_read_done     <= 1'b0;
            p0_write_done    <= 1'b0;
            p1_write_done    <= 1'b0;
        end else begin
            p0_read_done  <= 1'b0;
            p1_read_done  <= 1'b0;
            p0_write_done <= 1'b0;
            p1_write_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_elig || p1_elig) begin
                        grant_owner <= pick;
                        busy        <= 1'b1;
                        if (pick_write) begin
                            io_write_do      <= 1'b1;
                            io_write_address <= pick_addr;
                            io_write_length  <= pick_len;
                            io_write_data    <= pick_wdata;
                            state            <= WRITE;
                        end else begin
                            io_read_do      <= 1'b1;
                            io_read_address <= pick_addr;
                            io_read_length  <= pick_len;
                            state           <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (io_write_done) begin
                        io_write_do <= 1'b0;
                        busy        <= 1'b0;
                        rr_ptr      <= ~grant_owner;
                        state       <= IDLE;
                        if (grant_owner) p1_write_done <= 1'b1;
                        else             p0_write_done <= 1'b1;
                    end
                end
                READ: begin
                    if (io_read_done) begin
                        io_read_do <= 1'b0;
                        busy       <= 1'b0;
                        rr_ptr     <= ~grant_owner;
                        state      <= IDLE;
                        if (grant_owner) begin
                            p1_read_done <= 1'b1;
                            p1_read_data <= io_read_data;
                        end else begin
                            p0_read_done <= 1'b1;
                            p0_read_data <= io_read_data;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    io_read_do  <= 1'b0;
                    io_write_do <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
